// File: rtl/stream_demux2.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : stream_demux2                                                  |
// | Purpose  : Registered 1-to-2 valid/ready stream demultiplexer; one        |
// |            holding register per output, routed by the in_sel sideband.    |
// | Options  : STREAM_DEMUX2_STATS_EN adds 16-bit delivered-word counters     |
// |            count0/count1.                                                 |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module stream_demux2 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef STREAM_DEMUX2_STATS_EN
  ,
  output logic [15:0]      count0,
  output logic [15:0]      count1
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state [2];
  logic [WIDTH-1:0] r_data  [2];

  logic [1:0]       w_out_ready;
  logic [1:0]       w_out_valid;
  logic [1:0]       w_accept;
  logic [1:0]       w_drain;
  logic             w_sel_room;
  logic             w_in_accept;

  assign w_out_ready = {out1_ready, out0_ready};

  // Only the selected port gates the producer; the other port never blocks it.
  assign w_sel_room  = in_sel ? (~w_out_valid[1] | out1_ready)
                              : (~w_out_valid[0] | out0_ready);
  assign in_ready    = reset_n & w_sel_room;
  assign w_in_accept = in_valid & in_ready;

  always_comb begin
    w_out_valid = '0;
    w_accept    = '0;
    w_drain     = '0;
    for (int k = 0; k < 2; k++) begin
      w_out_valid[k] = (r_state[k] == ST_FULL);
      w_accept[k]    = w_in_accept & (in_sel == 1'(k));
      w_drain[k]     = w_out_valid[k] & w_out_ready[k];
    end
  end

  // Accept takes priority over drain so a simultaneous drain+fill stays FULL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        r_state[k] <= ST_EMPTY;
        r_data[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_accept[k]) begin
          r_state[k] <= ST_FULL;
          r_data[k]  <= in_data;
        end else if (w_drain[k]) begin
          r_state[k] <= ST_EMPTY;
        end
      end
    end
  end

  assign out0_valid = w_out_valid[0];
  assign out1_valid = w_out_valid[1];
  assign out0_data  = r_data[0];
  assign out1_data  = r_data[1];

`ifdef STREAM_DEMUX2_STATS_EN
  logic [15:0] r_count [2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        r_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_drain[k]) begin
          r_count[k] <= r_count[k] + 16'd1;
        end
      end
    end
  end

  assign count0 = r_count[0];
  assign count1 = r_count[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux2.sv
`default_nettype none
// Self-checking bench for stream_demux2: queue-based reference model with a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_stream_demux2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [31:0] in_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
`ifdef STREAM_DEMUX2_STATS_EN
  logic [15:0] count0;
  logic [15:0] count1;
`endif

  stream_demux2 #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef STREAM_DEMUX2_STATS_EN
    ,
    .count0     (count0),
    .count1     (count1)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each output is a FIFO of capacity one.
  logic [31:0] m_q0[$];
  logic [31:0] m_q1[$];
  int          m_cnt0 = 0;
  int          m_cnt1 = 0;

  function automatic bit m_full(input logic k);
    return k ? (m_q1.size() != 0) : (m_q0.size() != 0);
  endfunction

  function automatic bit m_ready();
    logic rdy;
    rdy = in_sel ? out1_ready : out0_ready;
    return reset_n && (!m_full(in_sel) || rdy);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q0.delete();
      m_q1.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      bit acc, d0, d1;
      acc = in_valid && m_ready();
      d0  = (m_q0.size() != 0) && out0_ready;
      d1  = (m_q1.size() != 0) && out1_ready;
      if (d0) begin void'(m_q0.pop_front()); m_cnt0++; end
      if (d1) begin void'(m_q1.pop_front()); m_cnt1++; end
      if (acc) begin
        if (in_sel) m_q1.push_back(in_data);
        else        m_q0.push_back(in_data);
      end
    end
  end

  always @(posedge clock) begin
    #2;
    chk("in_ready", in_ready, m_ready());
    chk("out0_valid", out0_valid, m_q0.size() != 0);
    chk("out1_valid", out1_valid, m_q1.size() != 0);
    if (m_q0.size() != 0) chk("out0_data", out0_data, m_q0[0]);
    if (m_q1.size() != 0) chk("out1_data", out1_data, m_q1[0]);
`ifdef STREAM_DEMUX2_STATS_EN
    chk("count0", count0, 16'(m_cnt0));
    chk("count1", count1, 16'(m_cnt1));
`endif
  end

  // Delivery logs for literal ordering / exactly-once checks.
  logic [31:0] dlog0[$];
  logic [31:0] dlog1[$];
  always @(posedge clock) begin
    if (reset_n && out0_valid && out0_ready && dlog0.size() < 64) dlog0.push_back(out0_data);
    if (reset_n && out1_valid && out1_ready && dlog1.size() < 64) dlog1.push_back(out1_data);
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic s, input logic [31:0] d, input int budget);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    for (int i = 0; i < budget && !done; i++) begin
      #1;
      if (in_ready) done = 1'b1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL send_accept: word %0h not accepted within %0d cycles", d, budget);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int hits;
    bit acc;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    idle(2);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_in_ready", in_ready, 0);
    reset_n = 1'b1;
    idle(1);

    // Reset mid-stream with both ports full.
    send(1'b0, 32'h100, 3);
    send(1'b1, 32'h200, 3);
    chk("t1_full0", out0_valid, 1);
    chk("t1_full1", out1_valid, 1);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("t1_async_v0", out0_valid, 0);
    chk("t1_async_v1", out1_valid, 0);
    chk("t1_async_d0", out0_data, 0);
    chk("t1_async_d1", out1_data, 0);
    chk("t1_async_rdy", in_ready, 0);
    @(negedge clock);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    #1 chk("t1_rdy_sel0", in_ready, 1);
    in_sel = 1'b1;
    #1 chk("t1_rdy_sel1", in_ready, 1);
    @(negedge clock);

    // Routing.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(1'b0, 32'hA5A5_0001, 3);
    #1;
    chk("t2_v0", out0_valid, 1);
    chk("t2_d0", out0_data, 32'hA5A5_0001);
    send(1'b1, 32'h5A5A_0002, 3);
    #1;
    chk("t2_v1", out1_valid, 1);
    chk("t2_d1", out1_data, 32'h5A5A_0002);
    idle(2);

    // Backpressure and in-order drain.
    dlog0.delete();
    out0_ready = 1'b0;
    send(1'b0, 32'h0000_0301, 3);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 32'h0000_0302;
    #1 chk("t3_stall_rdy", in_ready, 0);
    idle(3);
    chk("t3_hold_data", out0_data, 32'h0000_0301);
    out0_ready = 1'b1;
    send(1'b0, 32'h0000_0302, 3);
    send(1'b0, 32'h0000_0303, 3);
    idle(3);
    chk("t3_drain_cnt", dlog0.size(), 3);
    if (dlog0.size() == 3) begin
      chk("t3_order1", dlog0[0], 32'h0000_0301);
      chk("t3_order2", dlog0[1], 32'h0000_0302);
      chk("t3_order3", dlog0[2], 32'h0000_0303);
    end

    // Independence: out0 stalled full, out1 streams one word per cycle.
    out0_ready = 1'b0;
    send(1'b0, 32'h0000_00C0, 3);
    out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'h0000_0400 + i, 1);
      chk("t4_out0_held", out0_data, 32'h0000_00C0);
      chk("t4_out0_valid", out0_valid, 1);
    end
    out0_ready = 1'b1;
    idle(2);

    // Simultaneous drain and fill.
    dlog1.delete();
    out1_ready = 1'b0;
    send(1'b1, 32'h11, 3);
    chk("t5_first", out1_data, 32'h11);
    out1_ready = 1'b1;
    send(1'b1, 32'h22, 1);
    out1_ready = 1'b0;
    #1;
    chk("t5_valid", out1_valid, 1);
    chk("t5_data", out1_data, 32'h22);
    out1_ready = 1'b1;
    idle(2);
    hits = 0;
    foreach (dlog1[i]) if (dlog1[i] == 32'h11) hits++;
    chk("t5_once", hits, 1);
    chk("t5_total", dlog1.size(), 2);

    // Randomized traffic with stalls and legal retargeting.
    acc = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      out0_ready = ($urandom % 4) != 0;
      out1_ready = ($urandom % 3) != 0;
      if (acc || !in_valid) begin
        in_valid = ($urandom % 3) != 0;
        in_sel   = 1'($urandom);
        in_data  = $urandom;
      end else if (($urandom % 8) == 0) begin
        in_sel = ~in_sel;
      end
      #1 acc = in_valid && in_ready;
    end
    @(negedge clock);
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle(3);

`ifdef STREAM_DEMUX2_STATS_EN
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      in_data = 32'(i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    idle(2);
    for (int i = 0; i < 3; i++) send(1'b1, 32'h900 + i, 3);
    idle(2);
    chk("t6_count0", count0, 16'h0001);
    chk("t6_count1", count1, 16'h0003);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
